// File: rtl/change_dispenser_if.sv
`default_nettype none
// ============================================================================
//  Module   : change_dispenser_if
//  Purpose  : Bundles the vend-side inputs, the hopper handshake and the
//             status outputs of change_dispenser into one interface.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals
//    vend         : dispense strobe from the vending FSM
//    change[2:0]  : change owed in nickel units, valid with vend
//    hopper_ack   : hopper acknowledge for the current coin
//    dispense_req : request to the hopper to release coin_out
//    coin_out[2:0]: coin code (NICKEL=001, DIME=010, idle=000)
//    busy         : payout in progress
//    done         : one-cycle pulse when a payout completes
//    balance[2:0] : remaining nickel units of the active payout
//    overrun      : sticky, a vend was dropped (pending slot full)
//    fault        : sticky, the hopper timed out
//  Modports
//    master : the dispenser side
//    slave  : the environment side (vending FSM + hopper)
// ============================================================================
interface change_dispenser_if;
  logic       vend;
  logic [2:0] change;
  logic       hopper_ack;
  logic       dispense_req;
  logic [2:0] coin_out;
  logic       busy;
  logic       done;
  logic [2:0] balance;
  logic       overrun;
  logic       fault;

  modport master (
    input  vend, change, hopper_ack,
    output dispense_req, coin_out, busy, done, balance, overrun, fault
  );

  modport slave (
    output vend, change, hopper_ack,
    input  dispense_req, coin_out, busy, done, balance, overrun, fault
  );
endinterface
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
//  Module   : change_dispenser
//  Purpose  : Pays out change one coin at a time over a four-phase
//             request/acknowledge handshake with a coin hopper. Holds one
//             pending payout, detects a stalled hopper and flags overrun and
//             fault conditions.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TIMEOUT_CYCLES : cycles allowed per hopper_ack edge (2..255)
//  Ports
//    clock : rising-edge clock
//    reset : asynchronous active-low reset
//    bus   : change_dispenser_if.master (vend/change in, hopper handshake,
//            status outputs); every output is registered
// ============================================================================
module change_dispenser #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input wire logic           clock,
  input wire logic           reset,
  change_dispenser_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2,
    S_FAULT   = 2'd3
  } state_t;

  localparam logic [2:0] c_coin_idle    = 3'b000;
  localparam logic [2:0] c_coin_nickel  = 3'b001;
  localparam logic [2:0] c_coin_dime    = 3'b010;
  // The timer counts edges already spent waiting, so the edge that would
  // make it equal TIMEOUT_CYCLES is the one that faults.
  localparam logic [7:0] c_timeout_last = 8'(TIMEOUT_CYCLES - 1);

  state_t     r_state;
  logic [7:0] r_timer;
  logic       r_pend_valid;
  logic [2:0] r_pend_change;
  logic       r_dispense_req;
  logic [2:0] r_coin;
  logic       r_busy;
  logic       r_done;
  logic [2:0] r_balance;
  logic       r_overrun;
  logic       r_fault;

  logic       w_vend_valid;
  logic       w_active;
  logic       w_ack_edge;
  logic       w_finish;
  logic       w_timeout;
  logic [2:0] w_coin_value;

  function automatic logic [2:0] coin_for(input logic [2:0] amount);
    return (amount >= 3'd2) ? c_coin_dime : c_coin_nickel;
  endfunction

  assign w_vend_valid = bus.vend && (bus.change != 3'd0);
  assign w_active     = (r_state == S_REQ) || (r_state == S_RELEASE);
  // The edge each wait state is looking for: ack high in REQ, low in RELEASE.
  assign w_ack_edge   = (r_state == S_REQ) ? bus.hopper_ack : !bus.hopper_ack;
  assign w_finish     = (r_state == S_RELEASE) && !bus.hopper_ack && (r_balance == 3'd0);
  assign w_timeout    = (r_timer == c_timeout_last);
  assign w_coin_value = (r_coin == c_coin_dime) ? 3'd2 : 3'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_timer        <= 8'd0;
      r_pend_valid   <= 1'b0;
      r_pend_change  <= 3'd0;
      r_dispense_req <= 1'b0;
      r_coin         <= c_coin_idle;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_balance      <= 3'd0;
      r_overrun      <= 1'b0;
      r_fault        <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // Vends arriving mid-payout go to the pending slot. The completing
      // edge is handled below because its slot may be consumed or bypassed.
      if (w_active && w_vend_valid && !w_finish) begin
        if (r_pend_valid) begin
          r_overrun <= 1'b1;
        end else begin
          r_pend_valid  <= 1'b1;
          r_pend_change <= bus.change;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_vend_valid) begin
            r_state        <= S_REQ;
            r_balance      <= bus.change;
            r_coin         <= coin_for(bus.change);
            r_dispense_req <= 1'b1;
            r_busy         <= 1'b1;
            r_timer        <= 8'd0;
          end
        end

        S_REQ, S_RELEASE: begin
          if (!w_ack_edge) begin
            if (w_timeout) begin
              // Pending slot clear here overrides any store made above.
              r_state        <= S_FAULT;
              r_fault        <= 1'b1;
              r_dispense_req <= 1'b0;
              r_coin         <= c_coin_idle;
              r_busy         <= 1'b0;
              r_pend_valid   <= 1'b0;
              r_timer        <= 8'd0;
            end else begin
              r_timer <= r_timer + 8'd1;
            end
          end else if (r_state == S_REQ) begin
            r_state        <= S_RELEASE;
            r_balance      <= r_balance - w_coin_value;
            r_dispense_req <= 1'b0;
            r_timer        <= 8'd0;
          end else begin
            r_timer <= 8'd0;
            if (r_balance != 3'd0) begin
              r_state        <= S_REQ;
              r_coin         <= coin_for(r_balance);
              r_dispense_req <= 1'b1;
            end else begin
              r_done <= 1'b1;
              if (r_pend_valid) begin
                // Slot is still full on this edge, so a new vend is dropped.
                r_pend_valid   <= 1'b0;
                r_state        <= S_REQ;
                r_balance      <= r_pend_change;
                r_coin         <= coin_for(r_pend_change);
                r_dispense_req <= 1'b1;
                if (w_vend_valid) begin
                  r_overrun <= 1'b1;
                end
              end else if (w_vend_valid) begin
                r_state        <= S_REQ;
                r_balance      <= bus.change;
                r_coin         <= coin_for(bus.change);
                r_dispense_req <= 1'b1;
              end else begin
                r_state <= S_IDLE;
                r_coin  <= c_coin_idle;
                r_busy  <= 1'b0;
              end
            end
          end
        end

        default: begin
          // FAULT: everything holds until reset.
        end
      endcase
    end
  end

  assign bus.dispense_req = r_dispense_req;
  assign bus.coin_out     = r_coin;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.balance      = r_balance;
  assign bus.overrun      = r_overrun;
  assign bus.fault        = r_fault;

endmodule
`default_nettype wire
